// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// pe_pkg : shared state encoding, default widths and entry layout for the
//          parallel_pe result collector slice.
// Revision: 1.0
// ============================================================================
package pe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 8;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } pe_state_e;

  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } pe_entry_t;

endpackage
`default_nettype wire

// File: rtl/pe_result_fifo.sv
`default_nettype none
// ============================================================================
// pe_result_fifo : synchronous FIFO with flush, level and full/empty flags.
// Revision: 1.0
// ============================================================================
module pe_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop    = pop && !empty;
  assign w_push   = push && (!full || w_pop);
  assign w_wr_en  = flush ? push : w_push;
  assign w_wr_idx = flush ? '0 : r_wr_ptr[AW-1:0];
  assign rdata    = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      // Flush and a same-cycle push leave exactly one entry at slot 0.
      r_wr_ptr <= push ? C_PTR_ONE : '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/pe_result_collector.sv
`default_nettype none
// ============================================================================
// pe_result_collector : captures tagged parallel_pe results, buffers and
//          drains them, flags run completion. Optional result checking is
//          enabled by defining PE_RESULT_CHECK_EN.
// Revision: 1.0
// ============================================================================
module pe_result_collector
  import pe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = 4,
  parameter int NUM_INST = 4,
  parameter int TAG_W    = TAG_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_W-1:0]        pe_result,
  input  logic                     pe_vld_o,
`ifdef PE_RESULT_CHECK_EN
  input  logic [DATA_W-1:0]        exp_result,
  output logic [TAG_W-1:0]         err_cnt,
  output logic                     err,
`endif
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     done,
  output logic                     overflow
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_NUM_INST = CNT_W'(NUM_INST);
  localparam logic [LW-1:0]    C_LVL_ONE  = LW'(1);

  pe_state_e                r_state;
  pe_state_e                w_state_nxt;
  logic [CNT_W-1:0]         r_cap_cnt;
  logic [CNT_W-1:0]         w_cnt_base;
  logic [CNT_W-1:0]         w_cnt_nxt;
  logic                     r_overflow;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_pop;
  logic                     w_capture;
  logic                     w_accept;
  logic                     w_drop;
  logic [TAG_W+DATA_W-1:0]  w_wdata;
  logic [TAG_W+DATA_W-1:0]  w_rdata;

  // start restarts the tag sequence so a coincident strobe becomes tag 0.
  assign w_pop      = out_valid && out_ready;
  assign w_capture  = pe_vld_o && (start || r_state == COLLECT);
  assign w_accept   = w_capture && (start || !w_full || w_pop);
  assign w_drop     = w_capture && !w_accept;
  assign w_cnt_base = start ? '0 : r_cap_cnt;
  assign w_cnt_nxt  = w_cnt_base + CNT_W'(w_capture);
  assign w_wdata    = {TAG_W'(w_cnt_base), pe_result};

  pe_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAG_W + DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (start),
    .push  (w_capture),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  assign out_valid           = !w_empty;
  assign {out_tag, out_data} = w_rdata;
  assign done                = (r_state == DONE);
  assign overflow            = r_overflow;

  always_comb begin
    w_state_nxt = r_state;
    if (start) begin
      w_state_nxt = (w_cnt_nxt == C_NUM_INST) ? DRAIN : COLLECT;
    end else begin
      case (r_state)
        COLLECT: if (w_cnt_nxt == C_NUM_INST) w_state_nxt = DRAIN;
        DRAIN:   if (w_empty || (w_pop && fifo_level == C_LVL_ONE)) w_state_nxt = DONE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cap_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cap_cnt <= w_cnt_nxt;
      if (start)
        r_overflow <= 1'b0;
      else if (w_drop || (pe_vld_o && (r_state == DRAIN || r_state == DONE)))
        r_overflow <= 1'b1;
    end
  end

`ifdef PE_RESULT_CHECK_EN
  logic [TAG_W-1:0] r_err_cnt;
  logic             r_err;
  logic             w_mis;

  // Only results that actually enter the FIFO are compared.
  assign w_mis   = w_accept && (pe_result != exp_result);
  assign err_cnt = r_err_cnt;
  assign err     = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
      r_err     <= 1'b0;
    end else if (start) begin
      r_err_cnt <= TAG_W'(w_mis);
      r_err     <= w_mis;
    end else if (w_mis) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + TAG_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_result_collector.sv
`default_nettype none
// ============================================================================
// tb_pe_result_collector : directed, table-driven and random checks of
//          pe_result_collector against a queue-based reference model.
// Revision: 1.0
// ============================================================================
module tb_pe_result_collector;

  localparam int DW = 32;
  localparam int TW = 8;
  localparam int DEPTH = 4;
  localparam int NI = 4;
  localparam int LW = 3;
  localparam int MP_IDLE = 0, MP_COLLECT = 1, MP_DRAIN = 2, MP_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic pe_vld_o = 1'b0;
  logic out_ready = 1'b0;
  logic [DW-1:0] pe_result = '0;

  logic ov_a, dn_a, of_a, ov_b, dn_b, of_b;
  logic [DW-1:0] od_a, od_b;
  logic [TW-1:0] ot_a, ot_b;
  logic [LW-1:0] lv_a, lv_b;
`ifdef PE_RESULT_CHECK_EN
  logic [DW-1:0] exp_result = '0;
  logic [TW-1:0] ec_a, ec_b;
  logic er_a, er_b;
`endif

  always #5 clk = ~clk;

  pe_result_collector #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_INST(NI), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pe_result(pe_result), .pe_vld_o(pe_vld_o),
`ifdef PE_RESULT_CHECK_EN
    .exp_result(exp_result), .err_cnt(ec_a), .err(er_a),
`endif
    .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a), .out_tag(ot_a),
    .fifo_level(lv_a), .done(dn_a), .overflow(of_a));

  pe_result_collector #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_INST(6), .TAG_W(TW)) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start), .pe_result(pe_result), .pe_vld_o(pe_vld_o),
`ifdef PE_RESULT_CHECK_EN
    .exp_result(exp_result), .err_cnt(ec_b), .err(er_b),
`endif
    .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b), .out_tag(ot_b),
    .fifo_level(lv_b), .done(dn_b), .overflow(of_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic cmp_out(input string nm, input bit b, input logic ev, input logic [31:0] ed,
                         input logic [7:0] et, input logic [2:0] el, input logic edn, input logic eov);
    chk({nm, ".valid"}, 64'(b ? ov_b : ov_a), 64'(ev));
    chk({nm, ".data"},  64'(b ? od_b : od_a), 64'(ed));
    chk({nm, ".tag"},   64'(b ? ot_b : ot_a), 64'(et));
    chk({nm, ".level"}, 64'(b ? lv_b : lv_a), 64'(el));
    chk({nm, ".done"},  64'(b ? dn_b : dn_a), 64'(edn));
    chk({nm, ".ovf"},   64'(b ? of_b : of_a), 64'(eov));
  endtask

  // Reference model for the NUM_INST=4 instance: a queue of {tag,data} plus run phase.
  typedef struct { logic [7:0] tag; logic [31:0] data; } ent_t;
  ent_t mq[$];
  int   m_phase, m_cnt, m_errcnt;
  bit   m_done, m_ovf, m_err;

  task automatic model_reset();
    mq.delete();
    m_phase = MP_IDLE; m_cnt = 0; m_errcnt = 0;
    m_done = 0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit pop, acc;
    ent_t e;
    pop = (mq.size() > 0) && out_ready;
    if (start) begin
      mq.delete();
      m_cnt = 0; m_ovf = 0; m_err = 0; m_errcnt = 0;
      m_phase = MP_COLLECT; pop = 0;
    end
    if (m_phase == MP_COLLECT) begin
      acc = (mq.size() < DEPTH) || pop;
      if (pop) void'(mq.pop_front());
      if (pe_vld_o) begin
        if (acc) begin
          e.tag = 8'(m_cnt); e.data = pe_result;
          mq.push_back(e);
`ifdef PE_RESULT_CHECK_EN
          if (pe_result != exp_result) begin
            m_err = 1;
            if (m_errcnt < 255) m_errcnt++;
          end
`endif
        end else begin
          m_ovf = 1;
        end
        m_cnt++;
        if (m_cnt == NI) m_phase = MP_DRAIN;
      end
    end else begin
      if (pe_vld_o && m_phase != MP_IDLE) m_ovf = 1;
      if (pop) void'(mq.pop_front());
      if (m_phase == MP_DRAIN && mq.size() == 0) m_phase = MP_DONE;
    end
    m_done = (m_phase == MP_DONE);
  endtask

  task automatic cmp_model();
    ent_t h;
    h = '{tag: 8'h0, data: 32'h0};
    if (mq.size() > 0) h = mq[0];
    chk("model.valid", 64'(ov_a), 64'(mq.size() > 0));
    chk("model.data",  64'(od_a), 64'(h.data));
    chk("model.tag",   64'(ot_a), 64'(h.tag));
    chk("model.level", 64'(lv_a), 64'(mq.size()));
    chk("model.done",  64'(dn_a), 64'(m_done));
    chk("model.ovf",   64'(of_a), 64'(m_ovf));
`ifdef PE_RESULT_CHECK_EN
    chk("model.err",    64'(er_a), 64'(m_err));
    chk("model.errcnt", 64'(ec_a), 64'(m_errcnt));
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  typedef struct {
    logic st, vld; logic [31:0] res; logic rdy;
    logic ev; logic [31:0] ed; logic [7:0] et; logic [2:0] el; logic edn, eov;
  } vec_t;
  vec_t tbl [10];

  initial begin
    // back-pressure: fill to DEPTH with out_ready low, then drain on consecutive cycles
    tbl[0] = '{1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 8'd0, 3'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'h11, 8'd0, 3'd1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'h11, 8'd0, 3'd2, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'h11, 8'd0, 3'd3, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 32'h11, 8'd0, 3'd4, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'h11, 8'd0, 3'd4, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h22, 8'd1, 3'd3, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h33, 8'd2, 3'd2, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b1, 32'h44, 8'd3, 3'd1, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 32'h00, 8'd0, 3'd0, 1'b1, 1'b0};

    model_reset();
    #2;
    cmp_out("reset_a", 1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    cmp_out("reset_b", 1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic run
    out_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_vld_o = 1'b1; pe_result = 32'((i + 1) * 16); tick(); pe_vld_o = 1'b0;
      chk("basic.valid", 64'(ov_a), 64'(1));
      chk("basic.tag",   64'(ot_a), 64'(i));
      chk("basic.data",  64'(od_a), 64'((i + 1) * 16));
      if (i < 3) repeat (4) tick();
    end
    chk("basic.done_early", 64'(dn_a), 64'(0));
    tick();
    cmp_out("basic.end", 1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1, 1'b0);

    // back-pressure table
    for (int k = 0; k < 10; k++) begin
      start = tbl[k].st; pe_vld_o = tbl[k].vld; pe_result = tbl[k].res; out_ready = tbl[k].rdy;
      tick();
      cmp_out($sformatf("bp[%0d]", k), 1'b0, tbl[k].ev, tbl[k].ed, tbl[k].et, tbl[k].el, tbl[k].edn, tbl[k].eov);
    end
    start = 1'b0; pe_vld_o = 1'b0;

    // full push with simultaneous pop (NUM_INST=6 instance)
    out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_vld_o = 1'b1; pe_result = 32'h60 + 32'(i); tick();
    end
    pe_result = 32'h55; out_ready = 1'b1; tick(); pe_vld_o = 1'b0;
    cmp_out("fullpop", 1'b1, 1'b1, 32'h61, 8'd1, 3'd4, 1'b0, 1'b0);
    repeat (3) tick();
    chk("fullpop.tag4",  64'(ot_b), 64'(4));
    chk("fullpop.data4", 64'(od_b), 64'h55);
    tick();
    cmp_out("fullpop.end", 1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);

    // overflow: six strobes into a 4-deep FIFO with no drain
    out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pe_vld_o = 1'b1; pe_result = 32'h100 + 32'(i); tick();
    end
    pe_vld_o = 1'b0;
    cmp_out("ovf.full", 1'b1, 1'b1, 32'h100, 8'd0, 3'd4, 1'b0, 1'b1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("ovf.tag",  64'(ot_b), 64'(k));
      chk("ovf.data", 64'(od_b), 64'h100 + 64'(k));
      tick();
    end
    cmp_out("ovf.end", 1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b1, 1'b1);

    // restart coincident with a strobe while entries are buffered
    out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    pe_vld_o = 1'b1; pe_result = 32'h01; tick();
    pe_result = 32'h02; tick();
    chk("restart.pre_level", 64'(lv_a), 64'(2));
    start = 1'b1; pe_result = 32'hAA; tick(); start = 1'b0; pe_vld_o = 1'b0;
    cmp_out("restart", 1'b0, 1'b1, 32'hAA, 8'd0, 3'd1, 1'b0, 1'b0);

`ifdef PE_RESULT_CHECK_EN
    // mismatch on tag 2 only
    out_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pe_vld_o = 1'b1; pe_result = 32'h200 + 32'(i);
      exp_result = (i == 2) ? pe_result ^ 32'h1 : pe_result;
      tick(); pe_vld_o = 1'b0; tick();
    end
    chk("check.err",    64'(er_a), 64'(1));
    chk("check.errcnt", 64'(ec_a), 64'(1));
`endif

    // asynchronous reset in the middle of a run
    out_ready = 1'b0; start = 1'b1; tick(); start = 1'b0;
    pe_vld_o = 1'b1; pe_result = 32'h77; tick(); tick(); pe_vld_o = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    cmp_out("arst_a", 1'b0, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
    cmp_out("arst_b", 1'b1, 1'b0, 32'h0, 8'h0, 3'd0, 1'b0, 1'b0);
`ifdef PE_RESULT_CHECK_EN
    chk("arst.err",    64'(er_a), 64'(0));
    chk("arst.errcnt", 64'(ec_a), 64'(0));
`endif
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      start     = (n == 0) || ($urandom_range(0, 29) == 0);
      pe_vld_o  = 1'($urandom_range(0, 1));
      pe_result = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef PE_RESULT_CHECK_EN
      exp_result = ($urandom_range(0, 3) == 0) ? pe_result ^ 32'h4 : pe_result;
`endif
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
